// File: rtl/multicore_mem_ctrl.sv
// multicore_mem_ctrl: host-sequenced loader, runner and shared data-RAM
// arbiter for an N-core array. Every RAM-side output is registered, so the
// effect of a cycle-t input appears at t+1.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// S_IDLE     | waiting for go; mode/core_sel are sampled with it
// S_LOAD_IRAM| host beats written to the instruction RAM picked by core_sel
// S_LOAD_DRAM| host beats written to the shared data RAM
// S_RUN      | cores enabled; round-robin arbitration of the data RAM
// S_READBACK | host beats read from the data RAM, returned two cycles later
module multicore_mem_ctrl #(
  parameter int NUM_CORES = 2,
  parameter int CORE_W    = 1,
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic                          go_i,
  input  logic [1:0]                    mode_i,
  input  logic [CORE_W-1:0]             core_sel_i,
  input  logic                          ext_valid_i,
  input  logic                          ext_last_i,
  input  logic [ADDR_W-1:0]             ext_addr_i,
  input  logic [DATA_W-1:0]             ext_wdata_i,
  output logic [DATA_W-1:0]             ext_rdata_o,
  output logic                          ext_rvalid_o,
  output logic                          busy_o,
  output logic                          done_o,
  output logic                          err_o,
  output logic [NUM_CORES-1:0]          core_start_o,
  input  logic [NUM_CORES-1:0]          core_halt_i,
  input  logic [NUM_CORES-1:0]          core_req_i,
  input  logic [NUM_CORES-1:0]          core_we_i,
  input  logic [NUM_CORES*ADDR_W-1:0]   core_addr_i,
  input  logic [NUM_CORES*DATA_W-1:0]   core_wdata_i,
  output logic [NUM_CORES-1:0]          core_gnt_o,
  output logic [NUM_CORES-1:0]          core_rvalid_o,
  output logic [DATA_W-1:0]             core_rdata_o,
  output logic [NUM_CORES-1:0]          iram_we_o,
  output logic [ADDR_W-1:0]             iram_addr_o,
  output logic [DATA_W-1:0]             iram_wdata_o,
  output logic                          dram_en_o,
  output logic                          dram_we_o,
  output logic [ADDR_W-1:0]             dram_addr_o,
  output logic [DATA_W-1:0]             dram_wdata_o,
  input  logic [DATA_W-1:0]             dram_rdata_i
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD_IRAM = 3'd1,
    S_LOAD_DRAM = 3'd2,
    S_RUN       = 3'd3,
    S_READBACK  = 3'd4
  } state_e;

  state_e                 state_q;
  logic [CORE_W-1:0]      sel_q;
  logic [CORE_W-1:0]      ptr_q;
  logic                   busy_q;
  logic                   done_q;
  logic                   err_q;
  logic [NUM_CORES-1:0]   core_start_q;
  logic [NUM_CORES-1:0]   core_gnt_q;
  logic [NUM_CORES-1:0]   core_rvalid_q;
  logic [NUM_CORES-1:0]   iram_we_q;
  logic [ADDR_W-1:0]      iram_addr_q;
  logic [DATA_W-1:0]      iram_wdata_q;
  logic                   dram_en_q;
  logic                   dram_we_q;
  logic [ADDR_W-1:0]      dram_addr_q;
  logic [DATA_W-1:0]      dram_wdata_q;
  // Read issued this cycle (dram_en high): owner is the host or a core.
  logic                   rd_ext_q;
  logic                   rd_ext_last_q;
  logic [NUM_CORES-1:0]   rd_core_q;
  logic                   ext_rvalid_q;

  logic [NUM_CORES-1:0]   elig;
  logic                   pick_vld;
  int                     pick_idx;
  logic [CORE_W-1:0]      ptr_d;
  logic [NUM_CORES-1:0]   gnt_d;

  // Round-robin pick: first requester at or after the pointer, skipping the
  // core being granted this cycle so its held request is not served twice.
  always_comb begin
    elig     = core_req_i & ~core_gnt_q;
    pick_vld = 1'b0;
    pick_idx = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (!pick_vld && elig[(int'(ptr_q) + k) % NUM_CORES]) begin
        pick_vld = 1'b1;
        pick_idx = (int'(ptr_q) + k) % NUM_CORES;
      end
    end
    ptr_d = CORE_W'((pick_idx + 1) % NUM_CORES);
    gnt_d = pick_vld ? (NUM_CORES'(1) << pick_idx) : '0;
  end

  // Operation sequencer with all registered outputs.
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= S_IDLE;
      sel_q         <= '0;
      ptr_q         <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
      core_start_q  <= '0;
      core_gnt_q    <= '0;
      core_rvalid_q <= '0;
      iram_we_q     <= '0;
      iram_addr_q   <= '0;
      iram_wdata_q  <= '0;
      dram_en_q     <= 1'b0;
      dram_we_q     <= 1'b0;
      dram_addr_q   <= '0;
      dram_wdata_q  <= '0;
      rd_ext_q      <= 1'b0;
      rd_ext_last_q <= 1'b0;
      rd_core_q     <= '0;
      ext_rvalid_q  <= 1'b0;
    end else begin
      done_q        <= 1'b0;
      iram_we_q     <= '0;
      dram_en_q     <= 1'b0;
      dram_we_q     <= 1'b0;
      core_gnt_q    <= '0;
      rd_ext_q      <= 1'b0;
      rd_ext_last_q <= 1'b0;
      rd_core_q     <= '0;
      ext_rvalid_q  <= rd_ext_q;
      core_rvalid_q <= rd_core_q;

      // Readback finishes when its last data word is returned, after the
      // FSM has already gone back to idle.
      if (rd_ext_q && rd_ext_last_q) begin
        done_q <= 1'b1;
        busy_q <= 1'b0;
      end

      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            err_q  <= 1'b0;
            sel_q  <= core_sel_i;
            busy_q <= 1'b1;
            case (mode_i)
              2'b00: state_q <= S_LOAD_IRAM;
              2'b01: state_q <= S_LOAD_DRAM;
              2'b10: begin
                state_q      <= S_RUN;
                core_start_q <= '1;
              end
              default: state_q <= S_READBACK;
            endcase
          end
        end

        S_LOAD_IRAM: begin
          if (ext_valid_i) begin
            if (int'(sel_q) < NUM_CORES) begin
              iram_we_q    <= NUM_CORES'(1) << sel_q;
              iram_addr_q  <= ext_addr_i;
              iram_wdata_q <= ext_wdata_i;
            end else begin
              err_q <= 1'b1;
            end
            if (ext_last_i) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end

        S_LOAD_DRAM: begin
          if (ext_valid_i) begin
            dram_en_q    <= 1'b1;
            dram_we_q    <= 1'b1;
            dram_addr_q  <= ext_addr_i;
            dram_wdata_q <= ext_wdata_i;
            if (ext_last_i) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end
          end
        end

        S_READBACK: begin
          if (ext_valid_i) begin
            dram_en_q     <= 1'b1;
            dram_addr_q   <= ext_addr_i;
            rd_ext_q      <= 1'b1;
            rd_ext_last_q <= ext_last_i;
            if (ext_last_i) begin
              state_q <= S_IDLE;
            end
          end
        end

        S_RUN: begin
          if (pick_vld) begin
            core_gnt_q   <= gnt_d;
            dram_en_q    <= 1'b1;
            dram_we_q    <= core_we_i[pick_idx];
            dram_addr_q  <= core_addr_i[pick_idx*ADDR_W +: ADDR_W];
            dram_wdata_q <= core_wdata_i[pick_idx*DATA_W +: DATA_W];
            rd_core_q    <= core_we_i[pick_idx] ? '0 : gnt_d;
            ptr_q        <= ptr_d;
          end else if ((&core_halt_i) && (rd_core_q == '0)) begin
            // Only leave once the last granted read has returned its data.
            state_q      <= S_IDLE;
            core_start_q <= '0;
            done_q       <= 1'b1;
            busy_q       <= 1'b0;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign err_o         = err_q;
  assign core_start_o  = core_start_q;
  assign core_gnt_o    = core_gnt_q;
  assign core_rvalid_o = core_rvalid_q;
  assign iram_we_o     = iram_we_q;
  assign iram_addr_o   = iram_addr_q;
  assign iram_wdata_o  = iram_wdata_q;
  assign dram_en_o     = dram_en_q;
  assign dram_we_o     = dram_we_q;
  assign dram_addr_o   = dram_addr_q;
  assign dram_wdata_o  = dram_wdata_q;
  assign ext_rvalid_o  = ext_rvalid_q;
  // RAM read data passes straight through, gated so it reads 0 when idle.
  assign ext_rdata_o   = ext_rvalid_q ? dram_rdata_i : '0;
  assign core_rdata_o  = (core_rvalid_q != '0) ? dram_rdata_i : '0;

endmodule
